wts_ocm_bridge: RTL and testbench

Parametrised second-generation bus adapter between the OCM slot bus (req/ack, 16-bit address) and the wave-table sound core's register port, external sample-RAM port and audio outputs. It replaces fixed-latency ack generation with an explicit transaction FSM, an RD_WAIT-parametrised register-read latency, and a handshaken RAM port with ramack. It also provides a registered stereo/mono output stage of configurable width. It sits at SoC top level beside the core; the core is instantiated by the parent.

---
 rtl/wts_bridge_pkg.sv | 21 ++
 rtl/wts_bridge_mix.sv | 52 +++++
 rtl/wts_ocm_bridge.sv | 253 +++++++++++++++++++++++++
 tb/tb_wts_ocm_bridge.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wts_bridge_pkg.sv
// rtl/wts_bridge_pkg.sv - shared types and defaults for the OCM to wave-table bridge
package wts_bridge_pkg;

  // Transaction FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REG_WR,
    ST_REG_RD,
    ST_RAM_WAIT,
    ST_ACK,
    ST_HOLD
  } bridge_state_e;

  localparam int DEF_CORE_W = 12;
  localparam int DEF_OUT_W  = 15;
  localparam int DEF_RAM_AW = 21;

  // Read data returned when the sample RAM never answers
  localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

endpackage

// File: rtl/wts_bridge_mix.sv
// rtl/wts_bridge_mix.sv - registered stereo/mono audio output stage
module wts_bridge_mix
  import wts_bridge_pkg::*;
#(
  parameter int CORE_W = DEF_CORE_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic              clk21m,
  input  logic              reset,
  input  logic              sw_mono,
  input  logic [CORE_W-1:0] core_left,
  input  logic [CORE_W-1:0] core_right,
  output logic [OUT_W-1:0]  wavl,
  output logic [OUT_W-1:0]  wavr
);

  // The mono sum needs one guard bit above the core width.
  if (OUT_W < CORE_W + 1) begin : g_bad_out_w
    $error("wts_bridge_mix: OUT_W must be at least CORE_W+1");
  end

  logic [CORE_W:0]  mono_s;
  logic [OUT_W-1:0] wavl_d, wavr_d;
  logic [OUT_W-1:0] wavl_q, wavr_q;

  // Left-justify either the raw channels or the sign-extended sum into OUT_W bits
  always_comb begin
    mono_s = {core_left[CORE_W-1], core_left} + {core_right[CORE_W-1], core_right};
    if (sw_mono) begin
      wavl_d = OUT_W'(mono_s) << (OUT_W - CORE_W - 1);
      wavr_d = OUT_W'(mono_s) << (OUT_W - CORE_W - 1);
    end else begin
      wavl_d = OUT_W'(core_left) << (OUT_W - CORE_W);
      wavr_d = OUT_W'(core_right) << (OUT_W - CORE_W);
    end
  end

  // Output registers
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      wavl_q <= '0;
      wavr_q <= '0;
    end else begin
      wavl_q <= wavl_d;
      wavr_q <= wavr_d;
    end
  end

  assign wavl = wavl_q;
  assign wavr = wavr_q;

endmodule

// File: rtl/wts_ocm_bridge.sv
// rtl/wts_ocm_bridge.sv - OCM slot bus to wave-table core bridge; WTS_BRIDGE_TIMEOUT_EN adds a RAM wait timeout
module wts_ocm_bridge
  import wts_bridge_pkg::*;
#(
  parameter int CORE_W      = DEF_CORE_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int RD_WAIT     = 10,
  parameter int RAM_AW      = DEF_RAM_AW,
  parameter int RAM_TIMEOUT = 64
) (
  input  logic              clk21m,
  input  logic              reset,
  input  logic              req,
  input  logic              wrt,
  input  logic [15:0]       adr,
  input  logic [7:0]        dbo,
  output logic              ack,
  output logic [7:0]        dbi,
  input  logic              sw_mono,
  output logic              ramreq,
  output logic              ramwrt,
  output logic [RAM_AW-1:0] ramadr,
  output logic [7:0]        ramdbo,
  input  logic [7:0]        ramdbi,
  input  logic              ramack,
  output logic              core_wrreq,
  output logic              core_rdreq,
  output logic              core_wr_active,
  output logic              core_rd_active,
  output logic [14:0]       core_a,
  output logic [7:0]        core_d,
  input  logic [7:0]        core_q,
  input  logic              core_mem_ncs,
  input  logic [RAM_AW-14:0] core_mem_a,
  input  logic [CORE_W-1:0] core_left,
  input  logic [CORE_W-1:0] core_right,
  output logic [OUT_W-1:0]  wavl,
  output logic [OUT_W-1:0]  wavr
`ifdef WTS_BRIDGE_TIMEOUT_EN
  ,
  output logic              ram_timeout
`endif
);

  localparam int BANK_W = RAM_AW - 13;

  if (RAM_AW < 14) begin : g_bad_ram_aw
    $error("wts_ocm_bridge: RAM_AW must be at least 14");
  end
  if (RD_WAIT < 1 || RD_WAIT > 15) begin : g_bad_rd_wait
    $error("wts_ocm_bridge: RD_WAIT must be in 1..15");
  end
  if (RAM_TIMEOUT < 1) begin : g_bad_timeout
    $error("wts_ocm_bridge: RAM_TIMEOUT must be positive");
  end

  bridge_state_e state_q, state_d;

  logic [3:0]        cnt_q, cnt_d;
  logic              wrt_q, wrt_d;
  logic [14:0]       adr_q, adr_d;
  logic [7:0]        dbo_q, dbo_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [7:0]        dbi_q, dbi_d;
  logic              ack_q, ack_d;
  logic              ramreq_q, ramreq_d;
  logic              ramwrt_q, ramwrt_d;
  logic              wrreq_q, wrreq_d;
  logic              rdreq_q, rdreq_d;
  logic              wr_act_q, wr_act_d;
  logic              rd_act_q, rd_act_d;

`ifdef WTS_BRIDGE_TIMEOUT_EN
  localparam int TCNT_W = $clog2(RAM_TIMEOUT + 1);
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              tout_q, tout_d;
`endif

  // Bit 15 of the bus address only selects the slot upstream.
  logic unused_adr15;
  assign unused_adr15 = adr[15];

  // Next-state and output decode for the transaction FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wrt_d    = wrt_q;
    adr_d    = adr_q;
    dbo_d    = dbo_q;
    bank_d   = bank_q;
    rdata_d  = rdata_q;
    dbi_d    = dbi_q;
    ramwrt_d = ramwrt_q;
    wr_act_d = wr_act_q;
    rd_act_d = rd_act_q;
    ack_d    = 1'b0;
    ramreq_d = 1'b0;
    wrreq_d  = 1'b0;
    rdreq_d  = 1'b0;
`ifdef WTS_BRIDGE_TIMEOUT_EN
    tcnt_d   = tcnt_q;
    tout_d   = tout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          adr_d  = adr[14:0];
          dbo_d  = dbo;
          wrt_d  = wrt;
          bank_d = core_mem_a;
          if (!core_mem_ncs) begin
            state_d  = ST_RAM_WAIT;
            ramreq_d = 1'b1;
            ramwrt_d = wrt;
`ifdef WTS_BRIDGE_TIMEOUT_EN
            tcnt_d   = '0;
`endif
          end else if (wrt) begin
            state_d  = ST_REG_WR;
            wrreq_d  = 1'b1;
            wr_act_d = 1'b1;
          end else begin
            state_d  = ST_REG_RD;
            rdreq_d  = 1'b1;
            rd_act_d = 1'b1;
            cnt_d    = 4'(RD_WAIT);
          end
        end
      end
      ST_REG_WR: begin
        state_d = ST_ACK;
      end
      ST_REG_RD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_ACK;
          rdata_d = core_q;
        end
      end
      ST_RAM_WAIT: begin
        if (ramack) begin
          state_d = ST_ACK;
          rdata_d = ramdbi;
`ifdef WTS_BRIDGE_TIMEOUT_EN
          tcnt_d  = '0;
        end else if (tcnt_q == TCNT_W'(RAM_TIMEOUT - 1)) begin
          state_d = ST_ACK;
          rdata_d = TIMEOUT_FILL;
          tout_d  = 1'b1;
          tcnt_d  = '0;
        end else begin
          tcnt_d  = tcnt_q + 1'b1;
`endif
        end
      end
      ST_ACK: begin
        state_d  = ST_HOLD;
        ack_d    = 1'b1;
        wr_act_d = 1'b0;
        rd_act_d = 1'b0;
        if (!wrt_q) begin
          dbi_d = rdata_q;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and latched transfer registers
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wrt_q    <= 1'b0;
      adr_q    <= '0;
      dbo_q    <= '0;
      bank_q   <= '0;
      rdata_q  <= '0;
      dbi_q    <= '0;
      ack_q    <= 1'b0;
      ramreq_q <= 1'b0;
      ramwrt_q <= 1'b0;
      wrreq_q  <= 1'b0;
      rdreq_q  <= 1'b0;
      wr_act_q <= 1'b0;
      rd_act_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wrt_q    <= wrt_d;
      adr_q    <= adr_d;
      dbo_q    <= dbo_d;
      bank_q   <= bank_d;
      rdata_q  <= rdata_d;
      dbi_q    <= dbi_d;
      ack_q    <= ack_d;
      ramreq_q <= ramreq_d;
      ramwrt_q <= ramwrt_d;
      wrreq_q  <= wrreq_d;
      rdreq_q  <= rdreq_d;
      wr_act_q <= wr_act_d;
      rd_act_q <= rd_act_d;
    end
  end

`ifdef WTS_BRIDGE_TIMEOUT_EN
  // RAM wait counter and sticky timeout flag
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      tcnt_q <= '0;
      tout_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tout_q <= tout_d;
    end
  end

  assign ram_timeout = tout_q;
`endif

  assign ack            = ack_q;
  assign dbi            = dbi_q;
  assign ramreq         = ramreq_q;
  assign ramwrt         = ramwrt_q;
  assign ramadr         = {bank_q, adr_q[12:0]};
  assign ramdbo         = dbo_q;
  assign core_wrreq     = wrreq_q;
  assign core_rdreq     = rdreq_q;
  assign core_wr_active = wr_act_q;
  assign core_rd_active = rd_act_q;
  assign core_a         = adr_q;
  assign core_d         = dbo_q;

  wts_bridge_mix #(
    .CORE_W (CORE_W),
    .OUT_W  (OUT_W)
  ) u_mix (
    .clk21m     (clk21m),
    .reset      (reset),
    .sw_mono    (sw_mono),
    .core_left  (core_left),
    .core_right (core_right),
    .wavl       (wavl),
    .wavr       (wavr)
  );

endmodule

// File: tb/tb_wts_ocm_bridge.sv
// tb/tb_wts_ocm_bridge.sv - directed self-checking bench for wts_ocm_bridge
module tb_wts_ocm_bridge;

  logic        clk21m = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        wrt = 1'b0;
  logic [15:0] adr = '0;
  logic [7:0]  dbo = '0;
  logic        ack;
  logic [7:0]  dbi;
  logic        sw_mono = 1'b0;
  logic        ramreq;
  logic        ramwrt;
  logic [20:0] ramadr;
  logic [7:0]  ramdbo;
  logic [7:0]  ramdbi = '0;
  logic        ramack = 1'b0;
  logic        core_wrreq;
  logic        core_rdreq;
  logic        core_wr_active;
  logic        core_rd_active;
  logic [14:0] core_a;
  logic [7:0]  core_d;
  logic [7:0]  core_q = '0;
  logic        core_mem_ncs = 1'b1;
  logic [7:0]  core_mem_a = '0;
  logic [11:0] core_left = '0;
  logic [11:0] core_right = '0;
  logic [14:0] wavl;
  logic [14:0] wavr;
`ifdef WTS_BRIDGE_TIMEOUT_EN
  logic        ram_timeout;
`endif

  int checks = 0;
  int errors = 0;
  int lat, wrp, rdp, rrp, act, nack;

  wts_ocm_bridge #(
    .CORE_W      (12),
    .OUT_W       (15),
    .RD_WAIT     (10),
    .RAM_AW      (21),
    .RAM_TIMEOUT (64)
  ) dut (
    .clk21m         (clk21m),
    .reset          (reset),
    .req            (req),
    .wrt            (wrt),
    .adr            (adr),
    .dbo            (dbo),
    .ack            (ack),
    .dbi            (dbi),
    .sw_mono        (sw_mono),
    .ramreq         (ramreq),
    .ramwrt         (ramwrt),
    .ramadr         (ramadr),
    .ramdbo         (ramdbo),
    .ramdbi         (ramdbi),
    .ramack         (ramack),
    .core_wrreq     (core_wrreq),
    .core_rdreq     (core_rdreq),
    .core_wr_active (core_wr_active),
    .core_rd_active (core_rd_active),
    .core_a         (core_a),
    .core_d         (core_d),
    .core_q         (core_q),
    .core_mem_ncs   (core_mem_ncs),
    .core_mem_a     (core_mem_a),
    .core_left      (core_left),
    .core_right     (core_right),
    .wavl           (wavl),
    .wavr           (wavr)
`ifdef WTS_BRIDGE_TIMEOUT_EN
    ,
    .ram_timeout    (ram_timeout)
`endif
  );

  always #23 clk21m = ~clk21m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One bus transfer. n counts clock edges since the request was sampled;
  // lat is the n at which ack is first seen (-1 if never within the bound).
  task automatic xfer(input logic w, input logic [15:0] a, input logic [7:0] d,
                      input logic ncs, input int rack_at,
                      output int o_lat, output int o_wrp, output int o_rdp,
                      output int o_rrp, output int o_act);
    @(negedge clk21m);
    req = 1'b1; wrt = w; adr = a; dbo = d; core_mem_ncs = ncs;
    o_lat = -1; o_wrp = 0; o_rdp = 0; o_rrp = 0; o_act = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk21m);
      if (n > 0) req = 1'b0 | req;
      ramack = (n == rack_at);
      if (core_wrreq) o_wrp++;
      if (core_rdreq) o_rdp++;
      if (ramreq) o_rrp++;
      if (core_wr_active || core_rd_active) o_act++;
      if (ack) begin
        o_lat = n;
        break;
      end
    end
    req = 1'b0;
    ramack = 1'b0;
    @(negedge clk21m);
    chk("ack_single", {31'b0, ack}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk21m);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_dbi", {24'b0, dbi}, 32'd0);
    chk("rst_ramreq", {31'b0, ramreq}, 32'd0);
    chk("rst_wrreq", {31'b0, core_wrreq}, 32'd0);
    chk("rst_ramadr", {11'b0, ramadr}, 32'd0);
    chk("rst_core_a", {17'b0, core_a}, 32'd0);
    chk("rst_wavl", {17'b0, wavl}, 32'd0);
`ifdef WTS_BRIDGE_TIMEOUT_EN
    chk("rst_timeout", {31'b0, ram_timeout}, 32'd0);
`endif
    reset = 1'b0;

    // Register write
    xfer(1'b1, 16'h9800, 8'h5A, 1'b1, -1, lat, wrp, rdp, rrp, act);
    chk("wr_lat", lat, 32'd2);
    chk("wr_pulse", wrp, 32'd1);
    chk("wr_no_rd", rdp, 32'd0);
    chk("wr_no_ramreq", rrp, 32'd0);
    chk("wr_active_len", act, 32'd2);
    chk("wr_core_a", {17'b0, core_a}, 32'h1800);
    chk("wr_core_d", {24'b0, core_d}, 32'h5A);

    // Register read
    core_q = 8'hC3;
    xfer(1'b0, 16'h8123, 8'h00, 1'b1, -1, lat, wrp, rdp, rrp, act);
    chk("rd_lat", lat, 32'd11);
    chk("rd_pulse", rdp, 32'd1);
    chk("rd_active_len", act, 32'd11);
    chk("rd_dbi", {24'b0, dbi}, 32'hC3);
    core_q = 8'h11;
    repeat (3) @(negedge clk21m);
    chk("rd_dbi_held", {24'b0, dbi}, 32'hC3);

    // RAM read, ramack five cycles after ramreq
    core_mem_a = 8'h12;
    ramdbi = 8'h77;
    xfer(1'b0, 16'h1ABC, 8'h00, 1'b0, 5, lat, wrp, rdp, rrp, act);
    chk("ram_rd_lat", lat, 32'd7);
    chk("ram_rd_pulse", rrp, 32'd1);
    chk("ram_rd_no_core", wrp + rdp + act, 32'd0);
    chk("ram_rd_adr", {11'b0, ramadr}, 32'h25ABC);
    chk("ram_rd_wrt", {31'b0, ramwrt}, 32'd0);
    chk("ram_rd_dbi", {24'b0, dbi}, 32'h77);

    // RAM write, ramack in the ramreq cycle; dbi must not change
    core_mem_a = 8'h01;
    xfer(1'b1, 16'h0042, 8'hA5, 1'b0, 0, lat, wrp, rdp, rrp, act);
    chk("ram_wr_lat", lat, 32'd2);
    chk("ram_wr_pulse", rrp, 32'd1);
    chk("ram_wr_wrt", {31'b0, ramwrt}, 32'd1);
    chk("ram_wr_dbo", {24'b0, ramdbo}, 32'hA5);
    chk("ram_wr_adr", {11'b0, ramadr}, 32'h02042);
    chk("ram_wr_dbi", {24'b0, dbi}, 32'h77);

    // Stray ramack while idle
    nack = 0;
    ramack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk21m);
      if (ack) nack++;
    end
    ramack = 1'b0;
    chk("stray_ramack", nack, 32'd0);

    // Audio output stage
    core_left = 12'h7FF; core_right = 12'h7FF; sw_mono = 1'b1;
    repeat (2) @(negedge clk21m);
    chk("mono_l", {17'b0, wavl}, 32'h3FF8);
    chk("mono_r", {17'b0, wavr}, 32'h3FF8);
    core_right = 12'h800; sw_mono = 1'b0;
    repeat (2) @(negedge clk21m);
    chk("stereo_l", {17'b0, wavl}, 32'h3FF8);
    chk("stereo_r", {17'b0, wavr}, 32'h4000);
    core_left = 12'h800; sw_mono = 1'b1;
    repeat (2) @(negedge clk21m);
    chk("mono_neg", {17'b0, wavl}, 32'h4000);
    core_left = 12'h001; core_right = 12'hFFF;
    repeat (2) @(negedge clk21m);
    chk("mono_zero", {17'b0, wavr}, 32'h0000);
    core_left = 12'h123; sw_mono = 1'b0;

    // Reset in REG_RD with four cycles left on the counter
    core_q = 8'h3C;
    @(negedge clk21m);
    req = 1'b1; wrt = 1'b0; adr = 16'h8055; core_mem_ncs = 1'b1;
    repeat (7) @(negedge clk21m);
    reset = 1'b1;
    req = 1'b0;
    #1;
    chk("abort_ack", {31'b0, ack}, 32'd0);
    chk("abort_active", {31'b0, core_rd_active}, 32'd0);
    chk("abort_core_a", {17'b0, core_a}, 32'd0);
    chk("abort_dbi", {24'b0, dbi}, 32'd0);
    chk("abort_wavl", {17'b0, wavl}, 32'd0);
    nack = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk21m);
      if (ack) nack++;
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk21m);
      if (ack) nack++;
    end
    chk("abort_no_ack", nack, 32'd0);
    xfer(1'b0, 16'h8055, 8'h00, 1'b1, -1, lat, wrp, rdp, rrp, act);
    chk("post_rst_lat", lat, 32'd11);
    chk("post_rst_dbi", {24'b0, dbi}, 32'h3C);

`ifdef WTS_BRIDGE_TIMEOUT_EN
    // RAM read with no ramack
    xfer(1'b0, 16'h0100, 8'h00, 1'b0, -1, lat, wrp, rdp, rrp, act);
    chk("to_lat", lat, 32'd65);
    chk("to_dbi", {24'b0, dbi}, 32'hFF);
    chk("to_flag", {31'b0, ram_timeout}, 32'd1);
    xfer(1'b0, 16'h0100, 8'h00, 1'b0, 1, lat, wrp, rdp, rrp, act);
    chk("to_sticky", {31'b0, ram_timeout}, 32'd1);
    reset = 1'b1;
    #1;
    chk("to_cleared", {31'b0, ram_timeout}, 32'd0);
    @(negedge clk21m);
    reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
